tube_scheduler: RTL
===================

TUBE_SCHEDULER -- requirements
Module: tube_scheduler

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 16'hACE1, LFSR load value at reset (16'h0000 treated as 16'h0001).
REQ-002 SHALL have parameter NUM_STATES, default 5, number of legal tube_state codes (0..NUM_STATES-1, max 8).
REQ-003 SHALL have parameter SCORE_MAX, default 999, score saturation value.
REQ-004 clk_100hz  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse: begin game (IDLE) / return to IDLE (OVER).
REQ-007 pause  input  1  one-cycle pulse: toggle RUN/PAUSE.
REQ-008 collide  input  1  level, bird-tube collision detected.
REQ-009 tube_wrap  input  4  bit k one-cycle pulse when tube k leaves the left edge and re-enters on the right.
REQ-010 tube_state_0..tube_state_3  output  3 each  gap code per tube, drives the tube location units.
REQ-011 run_en  output  1  high only in RUN; gates tube motion and bird physics.
REQ-012 game_over  output  1  high only in OVER.
REQ-013 score  output  10  tubes passed, unsigned, saturating.
REQ-014 fsm_state  output  2  IDLE=0, RUN=1, PAUSE=2, OVER=3, for display/debug.

Function
REQ-015 All outputs SHALL be registered; any input effect SHALL be visible on the first rising edge after it is sampled (1-cycle latency).
REQ-016 FSM: IDLE -start-> RUN; RUN -collide-> OVER; RUN -pause-> PAUSE; PAUSE -pause-> RUN; PAUSE -collide-> stays PAUSE; OVER -start-> IDLE; all other inputs hold state.
REQ-017 Priority in RUN: collide > pause > tube_wrap; start SHALL be ignored in RUN and PAUSE.
REQ-018 IDLE and start: score cleared to 0; tube_state_k loaded with R(lfsr[3k+2:3k]) for k=0..3, simultaneously.
REQ-019 R(x) = x if x < NUM_STATES, else x - NUM_STATES; result always in 0..NUM_STATES-1.
REQ-020 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle in every state; never reaches 0.
REQ-021 RUN and tube_wrap[k]: tube_state_k loads R(lfsr[3k+2:3k]); tubes without a wrap pulse hold.
REQ-022 RUN: score increases by popcount(tube_wrap) per cycle, saturating at SCORE_MAX (no wrap-around).
REQ-023 Simultaneous wraps on multiple tubes SHALL all be honoured in the same cycle using distinct LFSR slices.
REQ-024 tube_wrap in IDLE, PAUSE, OVER, or in the RUN cycle where collide or pause is sampled, SHALL be ignored (no state reload, no score change).
REQ-025 OVER: score and tube_state_k frozen; game_over=1; run_en=0.
REQ-026 OVER and start: -> IDLE, score and tube states hold until next IDLE->RUN.

Reset
REQ-027 rst low SHALL immediately force: FSM IDLE, tube_state_0..3=0, score=0, run_en=0, game_over=0, fsm_state=0, LFSR=LFSR_SEED.
REQ-028 Reset asserted mid-game (any state) SHALL discard all progress; first edge after rst deasserts is normal IDLE operation.

Verification
REQ-029 Reset, start pulse -> next cycle fsm_state=1, run_en=1, score=0, each tube_state_k = R(seed-derived slice), all < 5.
REQ-030 RUN, tube_wrap=4'b0101 one cycle -> score +2, tube_state_0 and tube_state_2 reloaded, tubes 1 and 3 unchanged.
REQ-031 RUN with score=998, tube_wrap=4'b1111 -> score=999; further wraps keep 999.
REQ-032 RUN, collide and pause and tube_wrap=4'b0001 same cycle -> fsm_state=3, game_over=1, run_en=0, score and tube_state_0 unchanged; start -> fsm_state=0.
REQ-033 RUN, pause -> fsm_state=2, run_en=0; tube_wrap and collide ignored; pause -> fsm_state=1, run_en=1.
REQ-034 Random stimulus 10000 cycles -> every tube_state_k always < NUM_STATES, LFSR never 0, score monotonic except clears at IDLE->RUN, rst low mid-RUN -> all outputs reset immediately.

Source files
------------

// File: rtl/tube_scheduler.sv
// Tube scheduler: game FSM (IDLE/RUN/PAUSE/OVER), per-tube gap code selection
// from a free-running 16-bit LFSR, and a saturating score counter.
// Ports:
//   clk_100hz          sole clock, rising edge
//   rst                asynchronous active-low reset
//   start              pulse: IDLE->RUN, OVER->IDLE
//   pause              pulse: toggle RUN/PAUSE
//   collide            level: bird hit a tube (RUN->OVER)
//   tube_wrap[3:0]     bit k pulses when tube k wraps left->right
//   tube_state_0..3    gap code per tube, 0..NUM_STATES-1
//   run_en             high only in RUN
//   game_over          high only in OVER
//   score[9:0]         tubes passed, saturating at SCORE_MAX
//   fsm_state[1:0]     IDLE=0 RUN=1 PAUSE=2 OVER=3
module tube_scheduler #(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned NUM_STATES = 5,
  parameter int unsigned SCORE_MAX  = 999
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       collide,
  input  logic [3:0] tube_wrap,
  output logic [2:0] tube_state_0,
  output logic [2:0] tube_state_1,
  output logic [2:0] tube_state_2,
  output logic [2:0] tube_state_3,
  output logic       run_en,
  output logic       game_over,
  output logic [9:0] score,
  output logic [1:0] fsm_state
);

  localparam int unsigned NUM_TUBES = 4;
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned SCORE_W   = 10;
  // An all-zero seed would lock the LFSR, so it is bumped to 1.
  localparam logic [15:0]        SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CODE_W:0]    NS_W      = (CODE_W+1)'(NUM_STATES);
  localparam logic [SCORE_W:0]   SMAX_W    = (SCORE_W+1)'(SCORE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_e;

  state_e                             state_q, state_d;
  logic [SCORE_W-1:0]                 score_q, score_d;
  logic [NUM_TUBES-1:0][CODE_W-1:0]   tube_q, tube_d;
  logic [15:0]                        lfsr_q, lfsr_d;
  logic                               run_en_q, run_en_d;
  logic                               game_over_q, game_over_d;
  logic [2:0]                         wrap_cnt;
  logic [SCORE_W:0]                   score_sum;

  // Fold a raw 3-bit slice into the legal code range.
  function automatic logic [CODE_W-1:0] remap(input logic [CODE_W-1:0] x);
    if ({1'b0, x} < NS_W) remap = x;
    else                  remap = CODE_W'({1'b0, x} - NS_W);
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11; runs in every state.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Number of tubes passed this cycle and the saturated running total.
  always_comb begin
    wrap_cnt = '0;
    for (int k = 0; k < NUM_TUBES; k++) wrap_cnt = wrap_cnt + 3'(tube_wrap[k]);
    score_sum = (SCORE_W+1)'(score_q) + (SCORE_W+1)'(wrap_cnt);
  end

  // Next-state, score and tube-code logic.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    tube_d  = tube_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          score_d = '0;
          for (int k = 0; k < NUM_TUBES; k++) tube_d[k] = remap(lfsr_q[3*k +: 3]);
        end
      end
      S_RUN: begin
        // collide beats pause beats tube_wrap; wraps are dropped on exit cycles.
        if (collide) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else begin
          for (int k = 0; k < NUM_TUBES; k++) begin
            if (tube_wrap[k]) tube_d[k] = remap(lfsr_q[3*k +: 3]);
          end
          score_d = (score_sum > SMAX_W) ? SCORE_W'(SMAX_W) : score_sum[SCORE_W-1:0];
        end
      end
      S_PAUSE: begin
        if (pause) state_d = S_RUN;
      end
      S_OVER: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    run_en_d    = (state_d == S_RUN);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers.
  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      tube_q      <= '0;
      lfsr_q      <= SEED_EFF;
      run_en_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      tube_q      <= tube_d;
      lfsr_q      <= lfsr_d;
      run_en_q    <= run_en_d;
      game_over_q <= game_over_d;
    end
  end

  assign tube_state_0 = tube_q[0];
  assign tube_state_1 = tube_q[1];
  assign tube_state_2 = tube_q[2];
  assign tube_state_3 = tube_q[3];
  assign run_en       = run_en_q;
  assign game_over    = game_over_q;
  assign score        = score_q;
  assign fsm_state    = 2'(state_q);

endmodule
